// File: rtl/vga_mem_responder_pkg.sv
// Shared defaults and state encoding for the VGA memory responder.
// Prefetch states exist only when VGA_MEM_PREFETCH_EN is defined.
package vga_mem_responder_pkg;

   localparam int unsigned ADDR_W_DEF = 20;
   localparam int unsigned DATA_W_DEF = 48;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT     = 3'd2,
      ST_RESP     = 3'd3,
      ST_HOLD     = 3'd4
`ifdef VGA_MEM_PREFETCH_EN
      ,
      ST_PF_ISSUE = 3'd5,
      ST_PF_WAIT  = 3'd6
`endif
   } state_t;

endpackage

// File: rtl/vga_mem_responder_pf_buf.sv
// One-entry prefetch buffer (tag, valid, data) with hit compare and invalidate.
// Only built when VGA_MEM_PREFETCH_EN is defined.
`ifdef VGA_MEM_PREFETCH_EN
module vga_pf_buf
   import vga_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              inval,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit_c,
   output logic [DATA_W-1:0] data
);

   logic              valid_q;
   logic [ADDR_W-1:0] tag_q;

   // Invalidate has priority over a same-cycle fill.
   always_ff @(posedge clk) begin : pf_buf_regs
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data    <= '0;
      end else if (inval) begin
         valid_q <= 1'b0;
      end else if (wr_en) begin
         valid_q <= 1'b1;
         tag_q   <= wr_tag;
         data    <= wr_data;
      end
   end

   assign hit_c = valid_q && (tag_q == lookup_addr);

endmodule
`endif

// File: rtl/vga_mem_responder.sv
// Single-outstanding SRAM fetch responder for VGA scan-out.
// Define VGA_MEM_PREFETCH_EN to add a one-word sequential prefetch buffer.
module vga_mem_responder
   import vga_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_sel,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_valid,
   input  logic              vga_inval,
   output logic              sram_req,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic              sram_gnt,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              sram_rvalid
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] sram_addr_d;
   logic [DATA_W-1:0] vga_data_d;
   logic              vga_valid_d;
   logic              sram_req_d;
   logic              pf_hit_c;
   logic [DATA_W-1:0] pf_data;

`ifdef VGA_MEM_PREFETCH_EN
   logic pf_hit_raw_c;
   logic pf_wr_c;
   logic pf_discard_q, pf_discard_d;

   // sram_addr still holds the prefetch address while the read is in flight.
   vga_pf_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pf_buf (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (pf_wr_c),
      .wr_tag      (sram_addr),
      .wr_data     (sram_rdata),
      .inval       (vga_inval),
      .lookup_addr (vga_addr),
      .hit_c       (pf_hit_raw_c),
      .data        (pf_data)
   );

   assign pf_hit_c = pf_hit_raw_c & ~vga_inval;
`else
   logic unused_inval;

   assign unused_inval = vga_inval;
   assign pf_hit_c     = 1'b0;
   assign pf_data      = '0;
`endif

   // Next-state and next-output logic; every output below is registered.
   always_comb begin : next_state_logic
      state_d      = state_q;
      addr_d       = addr_q;
      vga_valid_d  = 1'b0;
      vga_data_d   = vga_data;
      sram_req_d   = sram_req;
      sram_addr_d  = sram_addr;
`ifdef VGA_MEM_PREFETCH_EN
      pf_wr_c      = 1'b0;
      pf_discard_d = pf_discard_q | vga_inval;
`endif
      case (state_q)
         ST_IDLE: begin
            if (vga_sel) begin
               addr_d = vga_addr;
               if (pf_hit_c) begin
                  vga_valid_d = 1'b1;
                  vga_data_d  = pf_data;
                  state_d     = ST_RESP;
               end else begin
                  sram_req_d  = 1'b1;
                  sram_addr_d = vga_addr;
                  state_d     = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (sram_gnt) begin
               sram_req_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (sram_rvalid) begin
               vga_valid_d = 1'b1;
               vga_data_d  = sram_rdata;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
`ifdef VGA_MEM_PREFETCH_EN
            sram_req_d   = 1'b1;
            sram_addr_d  = ADDR_W'(addr_q + 1'b1);
            pf_discard_d = 1'b0;
            state_d      = ST_PF_ISSUE;
`else
            state_d = ST_IDLE;
`endif
         end
`ifdef VGA_MEM_PREFETCH_EN
         ST_PF_ISSUE: begin
            if (sram_gnt) begin
               sram_req_d = 1'b0;
               state_d    = ST_PF_WAIT;
            end
         end
         ST_PF_WAIT: begin
            if (sram_rvalid) begin
               pf_wr_c = ~vga_inval & ~pf_discard_q;
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : state_regs
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         vga_valid    <= 1'b0;
         vga_data     <= '0;
         sram_req     <= 1'b0;
         sram_addr    <= '0;
`ifdef VGA_MEM_PREFETCH_EN
         pf_discard_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         vga_valid    <= vga_valid_d;
         vga_data     <= vga_data_d;
         sram_req     <= sram_req_d;
         sram_addr    <= sram_addr_d;
`ifdef VGA_MEM_PREFETCH_EN
         pf_discard_q <= pf_discard_d;
`endif
      end
   end

endmodule
